// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI frame controller: FSM state encoding,
// frame geometry constants and a helper that maps (byte, bit) onto the
// latched frame word.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int FRAME_BYTES   = 2;
    localparam int COUNTER_W     = 14;
    localparam int FRAME_W       = BITS_PER_BYTE * FRAME_BYTES;
    localparam int BIT_W         = $clog2(BITS_PER_BYTE);
    localparam int POS_W         = $clog2(FRAME_W);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        BYTE_GAP = 3'd3,
        SS_HOLD  = 3'd4
    } spi_state_e;

    // Byte 0 carries the upper counter bits zero-extended, byte 1 the low byte.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [COUNTER_W-1:0] value);
        return {{(FRAME_W - COUNTER_W){1'b0}}, value};
    endfunction

    // Byte 0 occupies the upper half of the frame word, byte 1 the lower half.
    function automatic logic [POS_W-1:0] frame_bit_pos(input logic byte_sel,
                                                       input logic [BIT_W-1:0] bit_idx);
        return {~byte_sel, bit_idx};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// Half-period tick generator for SCLK. While enabled, o_tick pulses for one
// clk cycle every CLK_DIV cycles. While disabled the counter is held at its
// reload value so the first tick after enabling lands exactly CLK_DIV cycles
// later.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   i_en   - count enable
//   o_tick - one-cycle pulse at the end of each half-period
// -----------------------------------------------------------------------------
module spi_clk_div #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == {DIV_W{1'b0}});

    // Countdown to zero then reload; reload also whenever disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {DIV_W{1'b0}};
        end else if (!i_en || (r_cnt == {DIV_W{1'b0}})) begin
            r_cnt <= DIV_RELOAD;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl
// SPI mode-0 master that sends a 14-bit counter as a two-byte frame, MSB
// first: byte 0 = {2'b00, counter[13:8]}, byte 1 = counter[7:0]. SS is held
// low for a setup gap, byte 0, an inter-byte gap, byte 1 and a hold gap.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-low reset
//   i_counter - value to transmit, sampled when a request is accepted
//   i_valid   - transmit request, held until accepted
//   o_ready   - request can be accepted (inverse of o_busy)
//   sclk      - SPI clock, idles low
//   mosi      - serial data, MSB first, low whenever ss is high
//   ss        - slave select, active low
//   o_busy    - frame in progress (any state but IDLE)
//   o_done    - one-cycle pulse when ss returns high at frame end
// -----------------------------------------------------------------------------
module spi_frame_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int GAP_CYC = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COUNTER_W-1:0] i_counter,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 ss,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_MSB    = BIT_W'(BITS_PER_BYTE - 1);

    spi_state_e         r_state;
    spi_state_e         w_state_nxt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic [BIT_W-1:0]   r_bit_idx;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic               r_byte_sel;
    logic               w_byte_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic               r_sclk;
    logic               w_sclk_nxt;
    logic               r_mosi;
    logic               w_mosi_nxt;
    logic               r_ss;
    logic               w_ss_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_busy;
    logic               r_ready;
    logic               w_busy_nxt;
    logic               w_tick;
    logic               w_div_en;

    assign w_div_en = (r_state == SHIFT);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_div_en),
        .o_tick (w_tick)
    );

    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign ss      = r_ss;
    assign o_done  = r_done;
    assign o_busy  = r_busy;
    assign o_ready = r_ready;

    // Next-state and next-output decode; outputs are computed for the
    // following cycle so every port comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_sel;
        w_frame_nxt = r_frame;
        w_sclk_nxt  = 1'b0;
        w_mosi_nxt  = 1'b0;
        w_ss_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ss_nxt = 1'b1;
                // The o_done cycle is still IDLE but must not accept, which
                // guarantees at least one cycle of ss high between frames.
                if (i_valid && !r_done) begin
                    w_frame_nxt = pack_frame(i_counter);
                    w_gap_nxt   = GAP_RELOAD;
                    w_state_nxt = SS_SETUP;
                    w_ss_nxt    = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SS_SETUP: begin
                if (r_gap_cnt == {GAP_W{1'b0}}) begin
                    w_state_nxt = SHIFT;
                    w_bit_nxt   = BIT_MSB;
                    w_byte_nxt  = 1'b0;
                    w_mosi_nxt  = r_frame[frame_bit_pos(1'b0, BIT_MSB)];
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            SHIFT: begin
                w_sclk_nxt = r_sclk;
                w_mosi_nxt = r_mosi;
                if (w_tick) begin
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else if (r_bit_idx != {BIT_W{1'b0}}) begin
                        // Falling edge: start the low phase of the next bit.
                        w_sclk_nxt = 1'b0;
                        w_bit_nxt  = r_bit_idx - BIT_W'(1);
                        w_mosi_nxt = r_frame[frame_bit_pos(r_byte_sel, r_bit_idx - BIT_W'(1))];
                    end else begin
                        w_sclk_nxt  = 1'b0;
                        w_mosi_nxt  = 1'b0;
                        w_gap_nxt   = GAP_RELOAD;
                        w_state_nxt = r_byte_sel ? SS_HOLD : BYTE_GAP;
                    end
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            BYTE_GAP: begin
                if (r_gap_cnt == {GAP_W{1'b0}}) begin
                    w_state_nxt = SHIFT;
                    w_bit_nxt   = BIT_MSB;
                    w_byte_nxt  = 1'b1;
                    w_mosi_nxt  = r_frame[frame_bit_pos(1'b1, BIT_MSB)];
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            SS_HOLD: begin
                if (r_gap_cnt == {GAP_W{1'b0}}) begin
                    w_state_nxt = IDLE;
                    w_ss_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ss_nxt    = 1'b1;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_gap_cnt  <= {GAP_W{1'b0}};
            r_bit_idx  <= {BIT_W{1'b0}};
            r_byte_sel <= 1'b0;
            r_frame    <= {FRAME_W{1'b0}};
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss       <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_byte_sel <= w_byte_nxt;
            r_frame    <= w_frame_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_ss       <= w_ss_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            r_ready    <= !w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_ctrl
// Scoreboarded bench: the driver pushes each accepted counter value into a
// queue; an SPI receiver/monitor decodes every frame from the pins and
// compares it against bytes derived arithmetically from the queued value.
// -----------------------------------------------------------------------------
module tb_spi_frame_ctrl;

    localparam int CLK_DIV   = 50;
    localparam int GAP_CYC   = 100;
    localparam int FRAME_CYC = 3 * GAP_CYC + 32 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] i_counter = 14'd0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    spi_frame_ctrl #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_counter (i_counter),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .sclk      (sclk),
        .mosi      (mosi),
        .ss        (ss),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Present a request and wait (bounded) until the DUT can take it.
    task automatic send(input logic [13:0] v);
        int n;
        n = 0;
        @(negedge clk);
        i_counter = v;
        i_valid   = 1'b1;
        while (!(o_ready && !o_done) && n < 4 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4 * FRAME_CYC) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: value %0d never accepted", v);
        end else begin
            exp_q.push_back(int'(v));
        end
        @(posedge clk);
        #1;
    endtask

    // Receiver and monitor: decode frames from the pins, score them.
    initial begin
        logic        prev_ss;
        logic        prev_sclk;
        logic        in_frame;
        int          low_cnt;
        int          rises;
        logic [15:0] cap;
        int          ev;
        prev_ss   = 1'b1;
        prev_sclk = 1'b0;
        in_frame  = 1'b0;
        low_cnt   = 0;
        rises     = 0;
        cap       = 16'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_ss   = 1'b1;
                prev_sclk = 1'b0;
                in_frame  = 1'b0;
                low_cnt   = 0;
                rises     = 0;
                cap       = 16'd0;
            end else begin
                check("ready_is_not_busy", int'(o_ready), int'(!o_busy));
                if (ss) begin
                    check("mosi_low_when_ss_high", int'(mosi), 0);
                    check("sclk_low_when_ss_high", int'(sclk), 0);
                end else begin
                    check("ready_low_in_frame", int'(o_ready), 0);
                end
                if (prev_ss && !ss) begin
                    in_frame = 1'b1;
                    low_cnt  = 0;
                    rises    = 0;
                    cap      = 16'd0;
                end
                if (!ss) begin
                    low_cnt++;
                    if (sclk && !prev_sclk) begin
                        cap = {cap[14:0], mosi};
                        rises++;
                    end
                end
                if (!prev_ss && ss && in_frame) begin
                    in_frame = 1'b0;
                    check("ss_low_cycles", low_cnt, FRAME_CYC);
                    check("sclk_rising_edges", rises, 16);
                    check("done_at_frame_end", int'(o_done), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got bits 0x%04h with nothing expected", cap);
                    end else begin
                        ev = exp_q.pop_front();
                        check("byte0", int'(cap[15:8]), ev / 256);
                        check("byte1", int'(cap[7:0]), ev % 256);
                        check("rx_counter", int'(cap[13:0]), ev);
                    end
                end else begin
                    check("no_stray_done", int'(o_done), 0);
                end
                prev_ss   = ss;
                prev_sclk = sclk;
            end
        end
    end

    // Stimulus.
    initial begin
        int n;
        int av;
        #23;
        check("rst_ss", int'(ss), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_ready", int'(o_ready), 1);
        @(negedge clk);
        reset = 1'b1;

        // Directed values with known byte splits.
        send(14'd1);     i_valid = 1'b0;
        send(14'd1234);  i_valid = 1'b0;
        send(14'd16383); i_valid = 1'b0;
        send(14'd0);     i_valid = 1'b0;

        // Random values; junk on i_counter with i_valid low must be ignored.
        for (int k = 0; k < 8; k++) begin
            send(14'($urandom_range(0, 16383)));
            i_valid   = 1'b0;
            i_counter = 14'($urandom);
        end

        // i_valid held across two frames; counter changes mid-frame to 6.
        send(14'd5);
        send(14'd6);
        i_valid = 1'b0;

        // Abort during the high phase of bit 3 of byte 1.
        av = int'($urandom_range(0, 16383));
        send(14'(av));
        i_valid = 1'b0;
        repeat (1460) @(negedge clk);
        check("abort_point_sclk_high", int'(sclk), 1);
        check("abort_point_mosi_bit3", int'(mosi), (av % 256 / 8) % 2);
        #2;
        reset = 1'b0;
        #1;
        check("abort_ss", int'(ss), 1);
        check("abort_sclk", int'(sclk), 0);
        check("abort_mosi", int'(mosi), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_ready", int'(o_ready), 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        send(14'd255);
        i_valid = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 3 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d frames outstanding", exp_q.size());
        end
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CLK_DIV  50  clk cycles per SCLK half-period (min 2; 50 gives 1 MHz SCLK at 100 MHz clk)
  GAP_CYC  100  clk cycles for SS setup, inter-byte gap and SS hold (min 1)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single system clock, rising edge
  reset  input  1  asynchronous, active-low reset
  i_counter  input  14  counter value to transmit
  i_valid  input  1  transmit request, held until accepted
  o_ready  output  1  high when a request can be accepted
  sclk  output  1  SPI clock, idles low (mode 0)
  mosi  output  1  serial data, MSB first
  ss  output  1  slave select, active low
  o_busy  output  1  high while a frame is in progress
  o_done  output  1  one-cycle pulse at frame end

Function
REQ-003 FSM states SHALL be IDLE, SS_SETUP, SHIFT, BYTE_GAP, SS_HOLD.
REQ-004 IDLE: o_ready=1, ss=1, sclk=0; i_valid=1 on a clk edge SHALL latch {2'b00,i_counter[13:8]} as byte 0 and i_counter[7:0] as byte 1, and go to SS_SETUP.
REQ-005 Outside IDLE, o_ready SHALL be 0 and i_valid SHALL be ignored; the latched value SHALL be stable for the whole frame.
REQ-006 SS_SETUP: ss=0 and sclk=0 for exactly GAP_CYC cycles, then SHIFT with bit index 7 of byte 0.
REQ-007 SHIFT, per bit: mosi driven with the current bit at the start of the low phase; sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. The slave samples on the sclk rising edge.
REQ-008 After bit 0 high phase: sclk returns low; byte 0 goes to BYTE_GAP, byte 1 goes to SS_HOLD.
REQ-009 BYTE_GAP: ss=0, sclk=0 for GAP_CYC cycles, then SHIFT byte 1 from bit 7.
REQ-010 SS_HOLD: ss=0, sclk=0 for GAP_CYC cycles; on the exit edge ss=1, o_done=1 for one cycle, state IDLE.
REQ-011 Frame length from ss fall to ss rise SHALL be 3*GAP_CYC + 32*CLK_DIV cycles (1900 at defaults).
REQ-012 o_busy SHALL be 1 in every state except IDLE; o_ready SHALL equal !o_busy.
REQ-013 A new request SHALL NOT be accepted in the cycle o_done is high, so ss stays high at least 1 cycle between frames.
REQ-014 mosi SHALL be 0 whenever ss=1; sclk SHALL never toggle while ss=1.
REQ-015 The divider and gap counters SHALL count down to 0 and reload; no counter may wrap through its maximum value.

Reset
REQ-016 While reset=0 (asynchronous): state=IDLE, ss=1, sclk=0, mosi=0, o_busy=0, o_done=0, o_ready=1, all counters and shift registers = 0.
REQ-017 Reset asserted mid-frame SHALL abort immediately with no o_done; the first frame after release starts a full frame.

Structure
REQ-018 Package spi_pkg SHALL hold the FSM state enum, BITS_PER_BYTE=8, FRAME_BYTES=2 and COUNTER_W=14.
REQ-019 One sub-module, spi_clk_div (CLK_DIV half-period tick generator with enable), SHALL be used; everything else stays in spi_frame_ctrl.

Verification
REQ-020 i_counter=1 -> MOSI bytes 0x00, 0x01; a slave_top receiver reports o_counter=1.
REQ-021 i_counter=1234 -> bytes 0x04, 0xD2; 16383 -> 0x3F, 0xFF; each decoded by the receiver.
REQ-022 Default parameters -> ss low for exactly 1900 cycles, 16 sclk rising edges, o_done a single 1-cycle pulse.
REQ-023 i_valid held high with values 5 then 6 -> two frames, o_ready low throughout each frame, ss high >=1 cycle between frames, 6 received second.
REQ-024 reset=0 during bit 3 of byte 1 -> ss=1, sclk=0 asynchronously, no o_done; next request 255 -> bytes 0x00, 0xFF.
